otg_hpi_responder: RTL

- Synthesizable target-side model of the EZ-OTG Host Port Interface.
- Answers the SoC's HPI PIO bus (2-bit address, active-low CS/R/W, 16-bit data each way) in place of the USB controller.
- Lets driver code be brought up and regressed on-board without the chip.
- Provides a word RAM reached through an auto-incrementing address register, a bidirectional mailbox pair to local logic, and a status register.

---
 rtl/otg_hpi_responder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/otg_hpi_responder.sv
// rtl/otg_hpi_responder.sv - target-side stand-in for the EZ-OTG Host Port Interface
//
// Answers the host's HPI PIO bus with a word RAM (auto-incrementing address
// register), a mailbox pair to local logic and a status register.
//
// Ports:
//   clk_clk, reset_reset          clock, asynchronous active-high reset
//   hpi_address[1:0]              0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
//   hpi_cs_n, hpi_r_n, hpi_w_n    active-low chip select / read / write strobes
//   hpi_data_in[15:0]             host write data
//   hpi_data_out[15:0], hpi_data_oe  host read data and its valid flag
//   hpi_int                       host interrupt (host-bound mailbox full)
//   loc_mbx_in_data/full/ack      host-to-local mailbox
//   loc_mbx_out_data/wr           local-to-host mailbox post
//   protocol_err                  sticky flag for all strobes low at once
module otg_hpi_responder #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [1:0]  hpi_address,
    input  logic        hpi_cs_n,
    input  logic        hpi_r_n,
    input  logic        hpi_w_n,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    output logic        hpi_int,
    output logic [15:0] loc_mbx_in_data,
    output logic        loc_mbx_in_full,
    input  logic        loc_mbx_in_ack,
    input  logic [15:0] loc_mbx_out_data,
    input  logic        loc_mbx_out_wr,
    output logic        protocol_err
);

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_MBX  = 2'd1;
    localparam logic [1:0] REG_ADDR = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

    typedef enum logic [2:0] {IDLE, WRITE, WR_HOLD, RD_WAIT, RD_HOLD} state_t;

    state_t             state;
    logic               armed;
    logic [15:0]        addr;
    logic [1:0]         cap_reg;
    logic [15:0]        cap_data;
    logic [CNT_W-1:0]   cnt;
    logic               in_full;
    logic [15:0]        out_data;
    logic               out_full;

    logic [15:0]        mem [2**ADDR_W];
    logic [15:0]        ram_q;

    logic               wr_act;
    logic               rd_act;
    logic               illegal;
    logic               start_wr;
    logic               start_rd;
    logic               ram_we;
    logic               wr_done;
    logic               rd_done;
    logic [15:0]        rd_mux;

    assign wr_act  = !hpi_cs_n && !hpi_w_n &&  hpi_r_n;
    assign rd_act  = !hpi_cs_n && !hpi_r_n &&  hpi_w_n;
    assign illegal = !hpi_cs_n && !hpi_r_n && !hpi_w_n;

    assign start_wr = (state == IDLE) && armed && wr_act;
    assign start_rd = (state == IDLE) && armed && rd_act && !wr_act;
    assign ram_we   = (state == WRITE) && (cap_reg == REG_DATA);

    // Completion points where post-access side effects apply. A read whose
    // strobe dropped before the latency expired still completes here.
    assign wr_done = (state == WR_HOLD) && !wr_act;
    assign rd_done = ((state == RD_WAIT) && (cnt == CNT_LAST) && !rd_act) ||
                     ((state == RD_HOLD) && !rd_act);

    always_comb begin
        rd_mux = 16'h0000;
        case (cap_reg)
            REG_DATA: rd_mux = ram_q;
            REG_MBX:  rd_mux = out_data;
            REG_ADDR: rd_mux = addr;
            REG_STAT: rd_mux = {14'b0, out_full, in_full};
            default:  rd_mux = 16'h0000;
        endcase
    end

    // RAM is not reset; its write enable is derived from state, so an
    // asynchronous reset in WRITE suppresses the commit.
    always_ff @(posedge clk_clk) begin
        if (ram_we)
            mem[addr[ADDR_W:1]] <= cap_data;
        if (start_rd)
            ram_q <= mem[addr[ADDR_W:1]];
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state           <= IDLE;
            armed           <= 1'b0;
            addr            <= 16'h0000;
            cap_reg         <= 2'd0;
            cap_data        <= 16'h0000;
            cnt             <= '0;
            hpi_data_out    <= 16'h0000;
            hpi_data_oe     <= 1'b0;
            loc_mbx_in_data <= 16'h0000;
            in_full         <= 1'b0;
            out_data        <= 16'h0000;
            out_full        <= 1'b0;
            protocol_err    <= 1'b0;
        end else begin
            // A strobe held across reset must not start an access until the
            // host has deselected the chip at least once.
            armed <= armed | hpi_cs_n;
            if (illegal)
                protocol_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_wr) begin
                        cap_reg  <= hpi_address;
                        cap_data <= hpi_data_in;
                        state    <= WRITE;
                    end else if (start_rd) begin
                        cap_reg <= hpi_address;
                        cnt     <= '0;
                        state   <= RD_WAIT;
                    end
                end
                WRITE: begin
                    if (cap_reg == REG_ADDR)
                        addr <= cap_data;
                    state <= WR_HOLD;
                end
                WR_HOLD: begin
                    if (wr_done) begin
                        if (cap_reg == REG_DATA)
                            addr <= addr + 16'd2;
                        state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        if (rd_act) begin
                            hpi_data_out <= rd_mux;
                            hpi_data_oe  <= 1'b1;
                            state        <= RD_HOLD;
                        end else begin
                            if (cap_reg == REG_DATA)
                                addr <= addr + 16'd2;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD_HOLD: begin
                    if (rd_done) begin
                        hpi_data_oe <= 1'b0;
                        if (cap_reg == REG_DATA)
                            addr <= addr + 16'd2;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Mailbox flags: later assignments win, so a host write beats a
            // local ack and a local post beats a host-read clear.
            if (loc_mbx_in_ack)
                in_full <= 1'b0;
            if ((state == WRITE) && (cap_reg == REG_MBX)) begin
                loc_mbx_in_data <= cap_data;
                in_full         <= 1'b1;
            end
            if (rd_done && (cap_reg == REG_MBX))
                out_full <= 1'b0;
            if (loc_mbx_out_wr) begin
                out_data <= loc_mbx_out_data;
                out_full <= 1'b1;
            end
        end
    end

    assign hpi_int         = out_full;
    assign loc_mbx_in_full = in_full;

endmodule
